// File: rtl/decoder_nxm_seq_pkg.sv
// Shared types and helpers for the registered N:M decoder and its dwell timer.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } dec_state_t;

    localparam int unsigned OUT_W_MIN = 2;
    localparam int unsigned OUT_W_CAP = 64;

    // Callers truncate to their own OUT_W; inversion happens before truncation.
    function automatic logic [OUT_W_CAP-1:0] onehot(input logic [5:0] idx, input bit active_low);
        logic [OUT_W_CAP-1:0] v;
        v = {{(OUT_W_CAP-1){1'b0}}, 1'b1} << idx;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/decoder_nxm_seq_if.sv
// Select handshake and registered decoder outputs.
interface decoder_nxm_seq_if #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned OUT_W = 4
);
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             sel_ready;
    logic [OUT_W-1:0] y;
    logic             y_valid;
    logic             wrap;
    logic             err;

    modport master (
        output sel, sel_valid,
        input  sel_ready, y, y_valid, wrap, err
    );

    modport slave (
        input  sel, sel_valid,
        output sel_ready, y, y_valid, wrap, err
    );
endinterface

// File: rtl/decoder_nxm_seq_dwell_timer.sv
// Loadable down-counter; tick_o flags that the current dwell has expired.
module decoder_dwell_timer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] value_i,
    input  logic               en_i,
    output logic               tick_o
);
    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/decoder_nxm_seq.sv
// Registered SEL_W-to-OUT_W one-hot decoder with select handshake and autonomous scan.
module decoder_nxm_seq
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned OUT_W      = 4,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               scan_dir,
    decoder_nxm_seq_if.slave   bus
);
    if (OUT_W < OUT_W_MIN || OUT_W > 2**SEL_W || OUT_W > OUT_W_CAP) begin : g_bad_out_w
        $error("decoder_nxm_seq: OUT_W out of legal range for SEL_W");
    end

    localparam logic [OUT_W-1:0] Y_IDLE   = {OUT_W{ACTIVE_LOW}};
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    dec_state_t       state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d, idx_step;
    logic [OUT_W-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             accept, in_range, step_wraps;
    logic             tick, tmr_load, tmr_en;

    assign bus.sel_ready = en & ~mode & ~rst;
    assign accept        = bus.sel_valid & bus.sel_ready;
    assign in_range      = 32'(bus.sel) < OUT_W;

    always_comb begin
        if (scan_dir) begin
            step_wraps = (idx_q == '0);
            idx_step   = step_wraps ? IDX_LAST : idx_q - 1'b1;
        end else begin
            step_wraps = (idx_q == IDX_LAST);
            idx_step   = step_wraps ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        if (!en) begin
            state_d   = IDLE;
            y_d       = Y_IDLE;
            y_valid_d = 1'b0;
        end else if (!mode) begin
            // A select accept wins over the plain SCAN->DECODE exit.
            if (accept) begin
                if (in_range) begin
                    idx_d     = bus.sel;
                    y_d       = OUT_W'(onehot(6'(bus.sel), ACTIVE_LOW));
                    y_valid_d = 1'b1;
                    state_d   = DECODE;
                end else begin
                    y_d       = Y_IDLE;
                    y_valid_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end else if (state_q == SCAN) begin
                state_d = DECODE;
            end
        end else if (state_q != SCAN) begin
            state_d   = SCAN;
            y_d       = OUT_W'(onehot(6'(idx_q), ACTIVE_LOW));
            y_valid_d = 1'b1;
            tmr_load  = 1'b1;
        end else if (tick) begin
            idx_d    = idx_step;
            y_d      = OUT_W'(onehot(6'(idx_step), ACTIVE_LOW));
            wrap_d   = step_wraps;
            tmr_load = 1'b1;
        end else begin
            tmr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            y_q       <= Y_IDLE;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    decoder_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (dwell),
        .en_i    (tmr_en),
        .tick_o  (tick)
    );

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.wrap    = wrap_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_decoder_nxm_seq.sv
// Two decoder configurations on shared stimulus, checked against a behavioural model.
module tb_decoder_nxm_seq;
    logic       clk = 1'b0;
    logic       rst, en, mode, scan_dir, sel_valid;
    logic [3:0] dwell;
    logic [2:0] sel;
    bit         chk_on = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    decoder_nxm_seq_if #(.SEL_W(3), .OUT_W(6)) ifa ();
    decoder_nxm_seq_if #(.SEL_W(2), .OUT_W(4)) ifb ();

    assign ifa.sel       = sel;
    assign ifa.sel_valid = sel_valid;
    assign ifb.sel       = sel[1:0];
    assign ifb.sel_valid = sel_valid;

    decoder_nxm_seq #(.SEL_W(3), .OUT_W(6), .ACTIVE_LOW(1'b0), .DWELL_W(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell), .scan_dir(scan_dir), .bus(ifa)
    );
    decoder_nxm_seq #(.SEL_W(2), .OUT_W(4), .ACTIVE_LOW(1'b1), .DWELL_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell), .scan_dir(scan_dir), .bus(ifb)
    );

    // Model: y is derived from (y_valid, idx); scanning tracks cycles spent on the current line.
    int N[2]  = '{6, 4};
    bit AL[2] = '{1'b0, 1'b1};
    int m_st[2], m_idx[2], m_age[2], m_hold[2];
    bit m_yv[2], m_wr[2], m_er[2];

    always @(posedge clk) begin
        for (int unsigned c = 0; c < 2; c++) begin
            int s;
            s = (c == 0) ? int'(sel) : int'(sel[1:0]);
            m_wr[c] = 1'b0;
            m_er[c] = 1'b0;
            if (rst) begin
                m_st[c] = 0; m_idx[c] = 0; m_age[c] = 0; m_hold[c] = 0; m_yv[c] = 1'b0;
            end else if (!en) begin
                m_st[c] = 0; m_yv[c] = 1'b0;
            end else if (!mode) begin
                if (sel_valid) begin
                    if (s < N[c]) begin
                        m_idx[c] = s; m_yv[c] = 1'b1; m_st[c] = 1;
                    end else begin
                        m_yv[c] = 1'b0; m_er[c] = 1'b1; m_st[c] = 0;
                    end
                end else if (m_st[c] == 2) begin
                    m_st[c] = 1;
                end
            end else if (m_st[c] != 2) begin
                m_st[c] = 2; m_yv[c] = 1'b1; m_age[c] = 0; m_hold[c] = int'(dwell);
            end else if (m_age[c] == m_hold[c]) begin
                if (scan_dir) begin
                    m_wr[c]  = (m_idx[c] == 0);
                    m_idx[c] = (m_idx[c] + N[c] - 1) % N[c];
                end else begin
                    m_wr[c]  = (m_idx[c] == N[c] - 1);
                    m_idx[c] = (m_idx[c] + 1) % N[c];
                end
                m_age[c] = 0; m_hold[c] = int'(dwell);
            end else begin
                m_age[c]++;
            end
        end
    end

    function automatic logic [7:0] exp_y(int c);
        logic [7:0] v;
        v = m_yv[c] ? 8'(1 << m_idx[c]) : 8'h00;
        if (AL[c]) v = ~v;
        return v & 8'((1 << N[c]) - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_y",      {2'b00, ifa.y}, exp_y(0));
            chk("a_yvalid", ifa.y_valid,    m_yv[0]);
            chk("a_wrap",   ifa.wrap,       m_wr[0]);
            chk("a_err",    ifa.err,        m_er[0]);
            chk("a_ready",  ifa.sel_ready,  en & ~mode & ~rst);
            chk("b_y",      {4'h0, ifb.y},  exp_y(1));
            chk("b_yvalid", ifb.y_valid,    m_yv[1]);
            chk("b_wrap",   ifb.wrap,       m_wr[1]);
            chk("b_err",    ifb.err,        m_er[1]);
            chk("b_ready",  ifb.sel_ready,  en & ~mode & ~rst);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [5:0] sweep_a[4] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000};
    logic [3:0] sweep_b[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] scan_up_b[13] = '{4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101,
                                  4'b1011, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b1110};
    logic [3:0] scan_dn_b[4] = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; sel_valid = 1'b0; dwell = '0; scan_dir = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        chk("lit_rst_a_y",  ifa.y,       6'b000000);
        chk("lit_rst_a_yv", ifa.y_valid, 1'b0);
        chk("lit_rst_b_y",  ifb.y,       4'b1111);

        rst = 1'b0; en = 1'b1; sel_valid = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            sel = 3'(k);
            tick();
            chk("lit_sweep_a", ifa.y, sweep_a[k]);
            chk("lit_sweep_b", ifb.y, sweep_b[k]);
            chk("lit_sweep_yv", ifa.y_valid, 1'b1);
        end

        sel = 3'd7;
        tick();
        chk("lit_range_err", ifa.err,     1'b1);
        chk("lit_range_y",   ifa.y,       6'b000000);
        chk("lit_range_yv",  ifa.y_valid, 1'b0);
        sel = 3'd5;
        tick();
        chk("lit_range_y5",  ifa.y,       6'b100000);
        chk("lit_range_err0", ifa.err,    1'b0);

        sel = 3'd0;
        tick();
        sel_valid = 1'b0; mode = 1'b1; dwell = 4'd2; scan_dir = 1'b0;
        for (int unsigned k = 0; k < 13; k++) begin
            tick();
            chk("lit_scan_up_y",    ifb.y,    scan_up_b[k]);
            chk("lit_scan_up_wrap", ifb.wrap, (k == 12) ? 1'b1 : 1'b0);
        end

        mode = 1'b0; sel_valid = 1'b1; sel = 3'd1;
        tick();
        sel_valid = 1'b0; mode = 1'b1; dwell = 4'd0; scan_dir = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            chk("lit_scan_dn_y",    ifb.y,    scan_dn_b[k]);
            chk("lit_scan_dn_wrap", ifb.wrap, (k == 2) ? 1'b1 : 1'b0);
        end

        dwell = 4'd5; scan_dir = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("lit_midrst_y",  ifa.y,       6'b000000);
        chk("lit_midrst_yv", ifa.y_valid, 1'b0);
        rst = 1'b0; dwell = 4'd0;
        repeat (3) tick();
        chk("lit_pre_en_y", ifa.y, 6'b000100);
        en = 1'b0;
        tick();
        chk("lit_en0_y",  ifa.y,       6'b000000);
        chk("lit_en0_yv", ifa.y_valid, 1'b0);
        tick();
        en = 1'b1;
        tick();
        chk("lit_resume_y", ifa.y, 6'b000100);

        for (int unsigned i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            if ($urandom_range(0, 39) == 0) scan_dir = ~scan_dir;
            sel       = 3'($urandom);
            sel_valid = 1'($urandom);
            dwell     = 4'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
